// File: rtl/mips_pkg.sv
// mips_pkg: shared FSM encoding and default parameters for the register file slice
package mips_pkg;
  typedef enum logic {CLEAR, READY} state_t;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 3;
  localparam int NRD_DEF = 2;
endpackage

// File: rtl/mips_scoreboard.sv
// mips_scoreboard: per-entry pending bits with reservation-over-write priority and busy lookup
module mips_scoreboard #(
  parameter int ADDR_W = 3,
  parameter int NRD = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  input  logic [NRD-1:0]    hit,
  output logic [NRD-1:0]    busy
);
  localparam int DEPTH = 2**ADDR_W;
  logic [DEPTH-1:0] pending;
  always_ff @(posedge clk) begin
    if (!rst_n) pending <= '0;
    else begin
      if (clr_en) pending[clr_addr] <= 1'b0;
      if (set_en) pending[set_addr] <= 1'b1;
    end
  end
  for (genvar g = 0; g < NRD; g++) begin : g_busy
    logic [ADDR_W-1:0] a;
    assign a = rd_addr[g*ADDR_W +: ADDR_W];
    assign busy[g] = en && a != '0 && pending[a] && !hit[g];
  end
endmodule

// File: rtl/mips_regfile_param.sv
// mips_regfile_param: parameterised register file with write-through bypass, scoreboard and post-reset clear
module mips_regfile_param
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NRD = NRD_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  rsv_en,
  input  logic [ADDR_W-1:0]     rsv_addr,
  output logic                  ready
);
  localparam int DEPTH = 2**ADDR_W;
  state_t state;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic wr_ok, rsv_ok;
  logic [NRD-1:0] hit;
  assign ready = state == READY;
  assign wr_ok = ready && wr_en && wr_addr != '0;
  assign rsv_ok = ready && rsv_en && rsv_addr != '0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= CLEAR;
      idx <= '0;
    end else if (state == CLEAR) begin
      idx <= idx + 1'b1;
      if (idx == ADDR_W'(DEPTH-1)) state <= READY;
    end
  end
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == CLEAR) mem[idx] <= '0;
      else if (wr_ok) mem[wr_addr] <= wr_data;
    end
  end
  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [ADDR_W-1:0] a;
    assign a = rd_addr[g*ADDR_W +: ADDR_W];
    assign hit[g] = wr_ok && wr_addr == a;
    assign rd_data[g*DATA_W +: DATA_W] = (!ready || a == '0) ? '0 : hit[g] ? wr_data : mem[a];
  end
  mips_scoreboard #(.ADDR_W(ADDR_W), .NRD(NRD)) u_sb (
    .clk(clk),
    .rst_n(rst_n),
    .en(ready),
    .set_en(rsv_ok),
    .set_addr(rsv_addr),
    .clr_en(wr_ok),
    .clr_addr(wr_addr),
    .rd_addr(rd_addr),
    .hit(hit),
    .busy(rd_busy)
  );
endmodule

// File: tb/tb_mips_regfile_param.sv
// tb_mips_regfile_param: randomized and directed stimulus checked by a queue-based scoreboard against a behavioural model
module tb_mips_regfile_param;
  localparam int DW = 32;
  localparam int AW = 3;
  localparam int NRD = 2;
  localparam int DEPTH = 2**AW;
  typedef struct {
    logic r;
    logic [NRD*DW-1:0] d;
    logic [NRD-1:0] b;
  } exp_t;
  logic clk = 0;
  logic rst_n = 0;
  logic [NRD*AW-1:0] rd_addr = '0;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0] rd_busy;
  logic wr_en = 0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic rsv_en = 0;
  logic [AW-1:0] rsv_addr = '0;
  logic ready;
  int checks = 0;
  int errors = 0;
  exp_t q[$];
  bit [DW-1:0] m_mem [DEPTH];
  bit m_pend [DEPTH];
  bit m_ready = 0;
  int m_cnt = 0;
  mips_regfile_param #(.DATA_W(DW), .ADDR_W(AW), .NRD(NRD)) dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .ready(ready)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (ready !== e.r) begin
        errors++;
        $display("FAIL ready: got %b expected %b at %0t", ready, e.r, $time);
      end
      for (int i = 0; i < NRD; i++) begin
        checks += 2;
        if (rd_data[i*DW +: DW] !== e.d[i*DW +: DW]) begin
          errors++;
          $display("FAIL rd_data[%0d]: got %h expected %h at %0t", i, rd_data[i*DW +: DW], e.d[i*DW +: DW], $time);
        end
        if (rd_busy[i] !== e.b[i]) begin
          errors++;
          $display("FAIL rd_busy[%0d]: got %b expected %b at %0t", i, rd_busy[i], e.b[i], $time);
        end
      end
    end
  end
  task automatic cyc(input logic rn, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                     input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                     input logic re, input logic [AW-1:0] ra);
    exp_t e;
    rst_n = rn; rd_addr = {a1, a0}; wr_en = we; wr_addr = wa; wr_data = wd; rsv_en = re; rsv_addr = ra;
    e.r = m_ready;
    e.d = '0;
    e.b = '0;
    for (int i = 0; i < NRD; i++) begin
      int a;
      bit h;
      a = int'(rd_addr[i*AW +: AW]);
      h = m_ready && we && wa != 0 && int'(wa) == a;
      if (m_ready && a != 0) begin
        e.d[i*DW +: DW] = h ? wd : m_mem[a];
        e.b[i] = m_pend[a] && !h;
      end
    end
    q.push_back(e);
    @(posedge clk);
    if (!rn) begin
      m_cnt = 0;
      m_ready = 0;
      foreach (m_pend[k]) m_pend[k] = 0;
    end else if (!m_ready) begin
      m_cnt++;
      if (m_cnt == DEPTH) begin
        m_ready = 1;
        foreach (m_mem[k]) m_mem[k] = '0;
      end
    end else begin
      if (we && wa != 0) begin
        m_mem[wa] = wd;
        m_pend[wa] = 0;
      end
      if (re && ra != 0) m_pend[ra] = 1;
    end
    #1;
  endtask
  task automatic idle(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    cyc(1, a0, a1, 0, 0, 0, 0, 0);
  endtask
  initial begin
    @(posedge clk);
    #1;
    repeat (2) cyc(0, 5, 3, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) idle(AW'(i), 5);
    idle(5, 1);
    cyc(1, 5, 2, 1, 5, 32'hDEADBEEF, 0, 0);
    idle(5, 5);
    cyc(1, 0, 5, 1, 0, 32'h12345678, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 1, 0);
    idle(0, 0);
    cyc(1, 0, 3, 0, 0, 0, 1, 3);
    idle(3, 3);
    cyc(1, 3, 3, 1, 3, 32'hA5A5_0003, 0, 0);
    idle(3, 3);
    cyc(1, 4, 1, 1, 4, 32'h0000_0044, 1, 4);
    idle(4, 4);
    cyc(0, 4, 5, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 5, 4, i == 2, 6, 32'hBAD0_0006, 0, 0);
    cyc(0, 6, 5, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) cyc(1, 6, 5, i == 3, 6, 32'hBAD1_0006, i == 4, 6);
    idle(6, 5);
    idle(4, 3);
    for (int n = 0; n < 600; n++)
      cyc($urandom_range(0, 99) != 0, AW'($urandom), AW'($urandom), 1'($urandom),
          AW'($urandom), $urandom, 1'($urandom), AW'($urandom));
    rst_n = 1; wr_en = 0; rsv_en = 0;
    @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d left expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mips_regfile_param.md
MIPS_REGFILE_PARAM -- requirements
Module: mips_regfile_param

Interface
REQ-001 Parameter DATA_W, default 32: register width in bits.
REQ-002 Parameter ADDR_W, default 3: address width; DEPTH = 2**ADDR_W entries.
REQ-003 Parameter NRD, default 2: number of read ports.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 rd_addr  in  NRD*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
REQ-007 rd_data  out  NRD*DATA_W  read data; port i occupies bits [i*DATA_W +: DATA_W].
REQ-008 rd_busy  out  NRD  port i addresses an entry with a pending, unwritten result.
REQ-009 wr_en  in  1  write request.
REQ-010 wr_addr  in  ADDR_W  write address.
REQ-011 wr_data  in  DATA_W  write data.
REQ-012 rsv_en  in  1  reserve request: mark an entry pending (instruction issue).
REQ-013 rsv_addr  in  ADDR_W  entry to reserve.
REQ-014 ready  out  1  high once the post-reset clear has completed; gates all requests.

Function
REQ-015 Entry 0 SHALL always read as 0; writes and reservations to address 0 SHALL be ignored.
REQ-016 Reads SHALL be combinational: rd_data[i] = array[rd_addr[i]], with zero latency.
REQ-017 Write-through bypass: when ready, wr_en=1, wr_addr!=0 and wr_addr==rd_addr[i], rd_data[i] SHALL equal wr_data in the same cycle.
REQ-018 A write SHALL commit on the rising edge when ready=1, wr_en=1 and wr_addr!=0; the new value is visible through the array from the next cycle.
REQ-019 Scoreboard: one pending bit per entry; rsv_en (ready=1, rsv_addr!=0) SHALL set pending[rsv_addr] on the edge.
REQ-020 A committed write SHALL clear pending[wr_addr] on the edge.
REQ-021 When rsv and write target the same address in the same cycle, pending SHALL end set (the new reservation wins); the data write still commits.
REQ-022 rd_busy[i] = pending[rd_addr[i]] AND NOT bypass-hit on port i; rd_busy[i] SHALL be 0 for address 0.
REQ-023 FSM states: CLEAR and READY. CLEAR writes 0 to entry idx each cycle and increments idx; on the edge that clears idx==DEPTH-1, the FSM SHALL go to READY.
REQ-024 ready SHALL be 1 only in READY.
REQ-025 While not ready, wr_en and rsv_en SHALL be ignored; rd_data SHALL be 0; rd_busy SHALL be 0.
REQ-026 ready SHALL rise after exactly DEPTH rising edges with rst_n=1 following reset.
REQ-027 In READY, the FSM SHALL remain in READY until reset.

Reset
REQ-028 On any rising edge with rst_n=0: state=CLEAR, idx=0, all pending=0, ready=0; array contents SHALL NOT be altered on that edge.
REQ-029 Reset asserted mid-CLEAR SHALL restart the clear from idx 0.
REQ-030 There SHALL be no file-based initialisation or dump; the power-up contents are defined only by the clear sequence.

Structure
REQ-031 The FSM state encoding (CLEAR/READY) and default parameter constants SHALL live in the shared package mips_pkg.
REQ-032 The scoreboard SHALL be a sub-module, mips_scoreboard (pending bits, set/clear priority, busy lookup); the array, bypass and FSM stay in the top.

Verification
REQ-033 Reset for 2 cycles, release -> ready=0 for 8 cycles, ready=1 after the 8th edge; all rd_data=0.
REQ-034 Write 0xDEADBEEF to reg 5 with rd_addr[0]=5 in the same cycle -> rd_data[0]=0xDEADBEEF combinationally; the next cycle with wr_en=0 still reads 0xDEADBEEF.
REQ-035 Write 0x12345678 to reg 0 -> rd_data for address 0 remains 0; rsv to reg 0 -> rd_busy stays 0.
REQ-036 rsv reg 3 -> rd_busy=1 on port reading 3; in the write cycle to reg 3, rd_busy=0 via bypass; afterwards pending is clear.
REQ-037 rsv and write of reg 4 in the same cycle -> data committed, rd_busy for 4 is 1 on the following cycle.
REQ-038 Assert rst_n=0 at idx=5 mid-clear, then release -> ready rises 8 edges after release; a wr_en pulse during the clear has no effect.
